// File: rtl/datacache_pkg.sv
// -----------------------------------------------------------------------------
// datacache_pkg
//   Shared geometry constants, field types and FSM state encoding for the
//   direct-mapped, write-back, write-allocate data cache.
//   Address split (32-bit byte address):
//     [31:7] tag | [6:5] index | [4:2] word select | [1:0] byte (ignored)
// -----------------------------------------------------------------------------
package datacache_pkg;

    localparam int CACHE_GROUP      = 4;    // number of lines
    localparam int CACHE_INDEX_LEN  = 2;
    localparam int CACHE_OFFSET_LEN = 5;
    localparam int WORD_SIZE        = 32;   // CPU word and address width
    localparam int BLOCK_SIZE       = 256;  // line width in bits
    localparam int BYTE_SIZE        = 8;
    localparam int CACHE_TAG_LEN    = WORD_SIZE - CACHE_INDEX_LEN - CACHE_OFFSET_LEN;
    localparam int WORDS_PER_BLOCK  = BLOCK_SIZE / WORD_SIZE;
    localparam int BYTES_PER_WORD   = WORD_SIZE / BYTE_SIZE;
    localparam int WORD_SEL_LEN     = 3;    // log2(WORDS_PER_BLOCK)

    typedef logic [CACHE_TAG_LEN-1:0]   tag_t;
    typedef logic [CACHE_INDEX_LEN-1:0] index_t;
    typedef logic [WORD_SEL_LEN-1:0]    wsel_t;
    typedef logic [WORD_SIZE-1:0]       word_t;
    typedef logic [BLOCK_SIZE-1:0]      block_t;
    typedef logic [BYTES_PER_WORD-1:0]  be_t;

    typedef enum logic [1:0] {
        DC_IDLE    = 2'd0,
        DC_EVICT   = 2'd1,
        DC_REFILL  = 2'd2,
        DC_RESPOND = 2'd3
    } dc_state_t;

    // Block-aligned memory address for a given tag/index pair.
    function automatic word_t block_addr(input tag_t tag, input index_t idx);
        return {tag, idx, {CACHE_OFFSET_LEN{1'b0}}};
    endfunction

endpackage

// File: rtl/datacache_if.sv
// -----------------------------------------------------------------------------
// datacache_if / datacache_mem_if
//   datacache_if     : load/store unit <-> cache request/response bus.
//                      master = CPU side, slave = cache side.
//     req, we, addr, wdata, be   request (driven by master)
//     ready, rvalid, rdata       response (driven by slave)
//   datacache_mem_if : cache <-> data memory block transaction bus.
//                      master = cache side, slave = memory side.
//     mem_req, mem_we, mem_addr, mem_wdata   transaction (driven by master)
//     mem_rdata, mem_ack                     completion (driven by slave)
// -----------------------------------------------------------------------------
interface datacache_if;
    import datacache_pkg::*;

    logic  req;
    logic  we;
    word_t addr;
    word_t wdata;
    be_t   be;
    logic  ready;
    logic  rvalid;
    word_t rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rvalid, rdata
    );
endinterface

interface datacache_mem_if;
    import datacache_pkg::*;

    logic   mem_req;
    logic   mem_we;
    word_t  mem_addr;
    block_t mem_wdata;
    block_t mem_rdata;
    logic   mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/datacache_line_merge.sv
// -----------------------------------------------------------------------------
// datacache_line_merge
//   Combinational byte-enable merge of one CPU word into a cache line.
//   Ports:
//     line_in   in   256  current line contents
//     wsel      in   3    word select within the line
//     wdata     in   32   store data
//     be        in   4    byte enables (all-zero for loads)
//     line_out  out  256  line with enabled bytes of the selected word replaced
//     word_out  out  32   selected word of line_out (load data or merged word)
// -----------------------------------------------------------------------------
module datacache_line_merge
    import datacache_pkg::*;
(
    input  block_t line_in,
    input  wsel_t  wsel,
    input  word_t  wdata,
    input  be_t    be,
    output block_t line_out,
    output word_t  word_out
);

    always_comb begin
        line_out = line_in;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if ((wsel == WORD_SEL_LEN'(w)) && be[b]) begin
                    line_out[w*WORD_SIZE + b*BYTE_SIZE +: BYTE_SIZE] =
                        wdata[b*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    always_comb begin
        word_out = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            if (wsel == WORD_SEL_LEN'(w)) begin
                word_out = line_out[w*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

endmodule

// File: rtl/datacache.sv
// -----------------------------------------------------------------------------
// datacache
//   Direct-mapped, write-back, write-allocate data cache (4 lines x 256 bits).
//   One outstanding CPU request. Hits complete with rvalid the cycle after
//   acceptance; misses optionally evict a dirty line, refill the block, then
//   spend one RESPOND cycle completing the latched access.
//   Ports:
//     clk    in   clock, all state changes on posedge
//     rst_n  in   synchronous active-low reset
//     cpu    slave modport of datacache_if (req/we/addr/wdata/be, ready/rvalid/rdata)
//     mem    master modport of datacache_mem_if (mem_req/mem_we/mem_addr/
//            mem_wdata, mem_rdata/mem_ack)
// -----------------------------------------------------------------------------
module datacache
    import datacache_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    datacache_if.slave      cpu,
    datacache_mem_if.master mem
);

    dc_state_t state, state_nxt;

    // Line state: Valid/Dirty are control and get reset; tag/data arrays do not.
    logic [CACHE_GROUP-1:0] valid;
    logic [CACHE_GROUP-1:0] dirty;
    tag_t                   tag_arr  [CACHE_GROUP];
    block_t                 data_arr [CACHE_GROUP];

    // Latched request (captured on accept, used by the miss path).
    tag_t   tag_p1;
    index_t idx_p1;
    wsel_t  wsel_p1;
    logic   we_p1;
    word_t  wdata_p1;
    be_t    be_p1;

    // Response registers.
    logic   rvalid_p1;
    word_t  rdata_p1;

    // Incoming request fields.
    tag_t   in_tag;
    index_t in_idx;
    wsel_t  in_wsel;
    logic   unused_addr_lsb;

    logic   accept;
    logic   hit;
    logic   ready;

    // Memory-side outputs (decoded from state).
    logic   mreq;
    logic   mwe;
    word_t  maddr;
    block_t mwdata;

    // Merge unit operands.
    block_t m_line_in;
    block_t m_line_out;
    wsel_t  m_wsel;
    word_t  m_wdata;
    be_t    m_be;
    word_t  m_word;

    assign in_tag          = cpu.addr[WORD_SIZE-1 -: CACHE_TAG_LEN];
    assign in_idx          = cpu.addr[CACHE_OFFSET_LEN +: CACHE_INDEX_LEN];
    assign in_wsel         = cpu.addr[2 +: WORD_SEL_LEN];
    assign unused_addr_lsb = ^cpu.addr[1:0];

    assign hit    = valid[in_idx] && (tag_arr[in_idx] == in_tag);
    assign accept = (state == DC_IDLE) && cpu.req;

    assign cpu.ready     = ready;
    assign cpu.rvalid    = rvalid_p1;
    assign cpu.rdata     = rdata_p1;
    assign mem.mem_req   = mreq;
    assign mem.mem_we    = mwe;
    assign mem.mem_addr  = maddr;
    assign mem.mem_wdata = mwdata;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM next state / outputs ----------------
    // Memory outputs come straight from state plus arrays/latches that cannot
    // change while a transaction is pending, so they are stable until mem_ack.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        mreq      = 1'b0;
        mwe       = 1'b0;
        maddr     = '0;
        mwdata    = '0;
        unique case (state)
            DC_IDLE: begin
                ready = 1'b1;
                if (cpu.req && !hit) begin
                    state_nxt = (valid[in_idx] && dirty[in_idx]) ? DC_EVICT : DC_REFILL;
                end
            end
            DC_EVICT: begin
                mreq   = 1'b1;
                mwe    = 1'b1;
                maddr  = block_addr(tag_arr[idx_p1], idx_p1);
                mwdata = data_arr[idx_p1];
                if (mem.mem_ack) begin
                    state_nxt = DC_REFILL;
                end
            end
            DC_REFILL: begin
                mreq  = 1'b1;
                maddr = block_addr(tag_p1, idx_p1);
                if (mem.mem_ack) begin
                    state_nxt = DC_RESPOND;
                end
            end
            DC_RESPOND: begin
                state_nxt = DC_IDLE;
            end
            default: begin
                state_nxt = DC_IDLE;
            end
        endcase
    end

    // Merge operand select. IDLE serves the incoming hit; REFILL computes the
    // response word straight from the arriving block so rvalid can be raised
    // on the ack edge; RESPOND merges a store into the installed line.
    // Loads use zero byte enables so word_out is the unmodified word.
    always_comb begin
        unique case (state)
            DC_REFILL: begin
                m_line_in = mem.mem_rdata;
                m_wsel    = wsel_p1;
                m_wdata   = wdata_p1;
                m_be      = we_p1 ? be_p1 : '0;
            end
            DC_RESPOND: begin
                m_line_in = data_arr[idx_p1];
                m_wsel    = wsel_p1;
                m_wdata   = wdata_p1;
                m_be      = we_p1 ? be_p1 : '0;
            end
            default: begin
                m_line_in = data_arr[in_idx];
                m_wsel    = in_wsel;
                m_wdata   = cpu.wdata;
                m_be      = cpu.we ? cpu.be : '0;
            end
        endcase
    end

    datacache_line_merge u_merge (
        .line_in  (m_line_in),
        .wsel     (m_wsel),
        .wdata    (m_wdata),
        .be       (m_be),
        .line_out (m_line_out),
        .word_out (m_word)
    );

    // ---------------- control: line flags and response ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid     <= '0;
            dirty     <= '0;
            rvalid_p1 <= 1'b0;
            rdata_p1  <= '0;
        end else begin
            rvalid_p1 <= 1'b0;
            unique case (state)
                DC_IDLE: begin
                    if (accept && hit) begin
                        rvalid_p1 <= 1'b1;
                        rdata_p1  <= m_word;
                        if (cpu.we) begin
                            dirty[in_idx] <= 1'b1;
                        end
                    end
                end
                DC_REFILL: begin
                    if (mem.mem_ack) begin
                        valid[idx_p1] <= 1'b1;
                        dirty[idx_p1] <= 1'b0;
                        rvalid_p1     <= 1'b1;
                        rdata_p1      <= m_word;
                    end
                end
                DC_RESPOND: begin
                    if (we_p1) begin
                        dirty[idx_p1] <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- data: request latch, tag and line arrays ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_p1   <= in_tag;
            idx_p1   <= in_idx;
            wsel_p1  <= in_wsel;
            we_p1    <= cpu.we;
            wdata_p1 <= cpu.wdata;
            be_p1    <= cpu.be;
        end
        if (accept && hit && cpu.we) begin
            data_arr[in_idx] <= m_line_out;
        end
        if ((state == DC_REFILL) && mem.mem_ack) begin
            data_arr[idx_p1] <= mem.mem_rdata;
            tag_arr[idx_p1]  <= tag_p1;
        end
        if ((state == DC_RESPOND) && we_p1) begin
            data_arr[idx_p1] <= m_line_out;
        end
    end

endmodule

// File: tb/tb_datacache.sv
// -----------------------------------------------------------------------------
// tb_datacache
//   Self-checking bench for datacache. A word-addressed backing memory and a
//   line-level cache picture (valid/dirty/tag/words per index) predict every
//   hit/miss, evict/refill transaction and returned word.
// -----------------------------------------------------------------------------
module tb_datacache;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    datacache_if     cpu_if ();
    datacache_mem_if mem_if ();

    datacache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu_if),
        .mem   (mem_if)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_model [logic [31:0]];
    bit          m_valid [4];
    bit          m_dirty [4];
    logic [24:0] m_tag   [4];
    logic [31:0] m_words [4][8];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backing memory: untouched words hold an address-derived pattern.
    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (mem_model.exists(wa)) return mem_model[wa];
        return {wa[15:0], ~wa[15:0]};
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_rd(base + 32'(4*i));
        return l;
    endfunction

    function automatic logic [255:0] model_line(input logic [1:0] idx);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = m_words[idx][i];
        return l;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endfunction

    // Apply the CPU access to the resident line and return the resulting word.
    function automatic logic [31:0] model_apply(input logic [1:0] idx, input logic [2:0] wi,
                                                input logic w, input logic [31:0] wd,
                                                input logic [3:0] b);
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) m_words[idx][wi][8*i +: 8] = wd[8*i +: 8];
            m_dirty[idx] = 1'b1;
        end
        return m_words[idx][wi];
    endfunction

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] b, input int dly, input bit abort);
        logic [1:0]   idx;
        logic [24:0]  tg;
        logic [2:0]   wi;
        logic [31:0]  base;
        logic [31:0]  vbase;
        logic [31:0]  exp_word;
        logic [255:0] line;
        bit           hit;
        bit           evict;
        idx   = a[6:5];
        tg    = a[31:7];
        wi    = a[4:2];
        base  = {tg, idx, 5'b0};
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        evict = !hit && m_valid[idx] && m_dirty[idx];

        chk1("ready_at_issue", cpu_if.ready, 1'b1);
        cpu_if.req   = 1'b1;
        cpu_if.we    = w;
        cpu_if.addr  = a;
        cpu_if.wdata = wd;
        cpu_if.be    = b;
        @(posedge clk); #1;
        cpu_if.req   = 1'b0;
        cpu_if.we    = 1'($urandom);
        cpu_if.addr  = $urandom;
        cpu_if.wdata = $urandom;
        cpu_if.be    = 4'($urandom);

        if (hit) begin
            exp_word = model_apply(idx, wi, w, wd, b);
            chk1("hit_rvalid", cpu_if.rvalid, 1'b1);
            chk32("hit_rdata", cpu_if.rdata, exp_word);
            chk1("hit_no_mem_req", mem_if.mem_req, 1'b0);
        end else begin
            chk1("miss_rvalid_low", cpu_if.rvalid, 1'b0);
            chk1("miss_ready_low", cpu_if.ready, 1'b0);
            if (evict) begin
                vbase = {m_tag[idx], idx, 5'b0};
                line  = model_line(idx);
                for (int c = 0; c <= dly; c++) begin
                    chk1("evict_req", mem_if.mem_req, 1'b1);
                    chk1("evict_we", mem_if.mem_we, 1'b1);
                    chk32("evict_addr", mem_if.mem_addr, vbase);
                    chk256("evict_data", mem_if.mem_wdata, line);
                    if (c == dly) mem_if.mem_ack = 1'b1;
                    @(posedge clk); #1;
                    mem_if.mem_ack = 1'b0;
                end
                for (int i = 0; i < 8; i++) mem_model[vbase + 32'(4*i)] = m_words[idx][i];
                m_valid[idx] = 1'b0;
            end
            for (int c = 0; c <= dly; c++) begin
                chk1("refill_req", mem_if.mem_req, 1'b1);
                chk1("refill_we", mem_if.mem_we, 1'b0);
                chk32("refill_addr", mem_if.mem_addr, base);
                if (c == dly) begin
                    if (abort) begin
                        rst_n = 1'b0;
                        @(posedge clk); #1;
                        rst_n = 1'b1;
                        chk1("abort_mem_req", mem_if.mem_req, 1'b0);
                        chk1("abort_ready", cpu_if.ready, 1'b1);
                        chk1("abort_rvalid", cpu_if.rvalid, 1'b0);
                        chk32("abort_rdata", cpu_if.rdata, 32'h0);
                        model_reset();
                        return;
                    end
                    mem_if.mem_rdata = mem_line(base);
                    mem_if.mem_ack   = 1'b1;
                end
                @(posedge clk); #1;
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = {$urandom, $urandom, $urandom, $urandom,
                                    $urandom, $urandom, $urandom, $urandom};
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            for (int i = 0; i < 8; i++) m_words[idx][i] = mem_rd(base + 32'(4*i));
            exp_word = model_apply(idx, wi, w, wd, b);
            chk1("respond_rvalid", cpu_if.rvalid, 1'b1);
            chk32("respond_rdata", cpu_if.rdata, exp_word);
            chk1("respond_ready_low", cpu_if.ready, 1'b0);
            chk1("respond_no_mem_req", mem_if.mem_req, 1'b0);
            @(posedge clk); #1;
            chk1("after_respond_rvalid", cpu_if.rvalid, 1'b0);
            chk1("after_respond_ready", cpu_if.ready, 1'b1);
        end
    endtask

    initial begin
        logic [31:0] ra;
        rst_n            = 1'b0;
        cpu_if.req       = 1'b0;
        cpu_if.we        = 1'b0;
        cpu_if.addr      = '0;
        cpu_if.wdata     = '0;
        cpu_if.be        = '0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        for (int i = 0; i < 4; i++) m_tag[i] = '0;
        model_reset();
        mem_model[32'h40] = 32'hDEADBEEF;

        repeat (2) @(posedge clk);
        #1;
        chk1("rst_ready", cpu_if.ready, 1'b1);
        chk1("rst_rvalid", cpu_if.rvalid, 1'b0);
        chk32("rst_rdata", cpu_if.rdata, 32'h0);
        chk1("rst_mem_req", mem_if.mem_req, 1'b0);
        chk1("rst_mem_we", mem_if.mem_we, 1'b0);
        chk32("rst_mem_addr", mem_if.mem_addr, 32'h0);
        chk256("rst_mem_wdata", mem_if.mem_wdata, 256'h0);
        rst_n = 1'b1;

        // Clean miss with a 3-cycle refill wait.
        access(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3, 1'b0);
        // Partial store hit, then load the same word next cycle.
        access(1'b1, 32'h0000_0044, 32'h1122_3344, 4'b0101, 0, 1'b0);
        access(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 1'b0);
        chk32("merged_word", m_words[2][1], 32'h0022_FF44);
        // Conflict on index 2 with the dirty line: evict then refill.
        access(1'b0, 32'h0000_00C0, 32'h0, 4'h0, 2, 1'b0);
        // Four back-to-back hits.
        for (int i = 0; i < 4; i++)
            access(1'b0, 32'h0000_00C0 + 32'(4*i), 32'h0, 4'h0, 0, 1'b0);
        // Store with no byte enables on a resident line.
        access(1'b1, 32'h0000_00C8, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0);

        // Spurious mem_ack while idle must be ignored.
        mem_if.mem_rdata = {8{32'hBAD0_BAD0}};
        mem_if.mem_ack   = 1'b1;
        @(posedge clk); #1;
        mem_if.mem_ack   = 1'b0;
        chk1("spurious_ready", cpu_if.ready, 1'b1);
        chk1("spurious_mem_req", mem_if.mem_req, 1'b0);
        chk1("spurious_rvalid", cpu_if.rvalid, 1'b0);
        access(1'b0, 32'h0000_00C4, 32'h0, 4'h0, 0, 1'b0);

        // Random traffic over 8 tags so hits, clean and dirty misses all occur.
        for (int n = 0; n < 250; n++) begin
            ra = $urandom_range(0, 1023);
            ra[1:0] = 2'b00;
            access(1'($urandom), ra, $urandom, 4'($urandom), $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk1("idle_rvalid", cpu_if.rvalid, 1'b0);
            end
        end

        // Reset during a refill wait, then the same load misses again.
        access(1'b0, 32'h0000_3200, 32'h0, 4'h0, 2, 1'b1);
        access(1'b0, 32'h0000_3200, 32'h0, 4'h0, 1, 1'b0);
        access(1'b0, 32'h0000_0044, 32'h0, 4'h0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
